pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-width core PC register.
- Adds a configurable reset vector and step, a boot-delay counter, and a fetch valid/ready handshake.
- Redirects are prioritised: trap over jump. A jump that arrives during a stall is buffered until the stall drops.
- Adds a HALT state for debug. Sits between the EX/trap logic and the instruction-fetch port.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (low ADDR_W bits used).
- STEP, 4, sequential increment in bytes; power of two, at least 1.
- BOOT_DELAY, 2, cycles spent in BOOT with no fetch issued; at least 1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- trap_valid_i  in  1  trap redirect request.
- trap_addr_i  in  ADDR_W  trap target.
- jump_valid_i  in  1  branch/jump redirect request.
- jump_addr_i  in  ADDR_W  jump target.
- stall_i  in  1  pipeline stall; holds the PC.
- halt_i  in  1  debug halt request.
- resume_i  in  1  debug resume request.
- fetch_ready_i  in  1  fetch port accepts pc_o this cycle.
- pc_o  out  ADDR_W  current fetch PC.
- fetch_valid_o  out  1  pc_o is a valid fetch request.
- state_o  out  2  00 BOOT, 01 RUN, 10 HALT.
- pend_o  out  1  a buffered jump is pending.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-high on rst_i.
- Reset values: pc_o=RESET_VEC, state=BOOT, boot counter=0, fetch_valid_o=0, pend_o=0, pending address=0.
- Reset asserted mid-operation clears everything at once, including any pending jump and any HALT state.
- fetch_valid_o = (state==RUN) & ~stall_i. This is combinational from state and stall_i.
- BOOT state:
  - Counter increments each cycle; PC holds.
  - When the counter reaches BOOT_DELAY-1, next state is RUN.
  - Redirect inputs are ignored during BOOT.
- RUN state, priority per rising edge (highest first):
  1. trap_valid_i: pc_o <= trap_addr_i, pending jump cleared. Applies even while stall_i or halt_i is high. On the same edge halt_i still moves the state to HALT.
  2. jump_valid_i & ~stall_i: pc_o <= jump_addr_i, pending jump cleared. Applies regardless of fetch_ready_i; the fetch port is retargeted.
  3. jump_valid_i & stall_i: jump_addr_i latched into the pending register, pend_o <= 1. A newer jump overwrites an older pending one. PC holds.
  4. pend_o & ~stall_i: pc_o <= pending address, pend_o <= 0.
  5. fetch_ready_i & ~stall_i: pc_o <= pc_o + STEP, modulo 2^ADDR_W (all-ones minus STEP+1 wraps to 0).
  6. Otherwise the PC holds.
- Redirect latency: one edge. A target is visible on pc_o the cycle after the valid is sampled.
- halt_i in RUN: next state is HALT. Sequential advance (rule 5) is suppressed on that edge. Rules 1-4 still apply on that edge.
- HALT state:
  - fetch_valid_o=0 and PC holds; jumps are ignored.
  - The pending jump is retained.
  - trap_valid_i loads the trap target and returns to RUN.
  - resume_i returns to RUN; the pending jump is applied in the first RUN cycle with stall_i low.
  - halt_i and resume_i both high: resume wins.
- Illegal state encoding 11 recovers to RUN on the next edge.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- Defined:
  - Extra outputs misalign_o (1 bit) and misalign_addr_o (ADDR_W bits) are present.
  - A redirect target (trap, jump or pending) with any of its low log2(STEP) bits nonzero is not loaded; the PC holds.
  - misalign_o pulses high for one cycle after the offending edge, and misalign_addr_o captures the target.
  - A pending jump found misaligned is dropped and pend_o cleared.
  - With STEP=1 no checking occurs. Reset value of both outputs is 0.
- Not defined: the outputs are absent and targets load unchanged.

Test Plan:
- Reset with RESET_VEC=32'h8000_0000, BOOT_DELAY=2 -> pc_o=8000_0000 and fetch_valid_o=0 for 2 cycles. Then RUN, and with fetch_ready_i=1, pc_o=8000_0004 and 8000_0008 on consecutive cycles.
- jump_valid_i=1 with jump_addr_i=0x100 while stall_i=1 for 3 cycles, then a jump to 0x200 on the next stall cycle -> pend_o=1 and pc unchanged; one cycle after stall_i falls, pc_o=0x200 and pend_o=0.
- trap_valid_i and jump_valid_i both high on the same cycle (trap 0x40, jump 0x300), with stall_i=1 -> pc_o=0x40 next cycle and pend_o=0.
- halt_i pulse in RUN, then 5 idle cycles, then resume_i -> state_o=10, fetch_valid_o=0, PC frozen; after resume, state_o=01 and increments continue from the frozen PC.
- ADDR_W=8, pc=0xFC, STEP=4, fetch_ready_i=1 -> pc_o=0x00 next cycle. Asserting rst_i mid-stall with pend_o=1 -> pc_o=RESET_VEC, pend_o=0 and state BOOT immediately, without waiting for a clock edge.
- PC_ALIGN_CHK_EN defined: jump to 0x102 -> pc holds, misalign_o=1 for one cycle, misalign_addr_o=0x102. Jump to 0x104 -> loads normally.

Source files
------------

// File: rtl/pc_gen.sv
// Program-counter generator: boot delay, trap/jump redirects with stall buffering, debug halt.
// Optional macro PC_ALIGN_CHK_EN adds misaligned-target rejection with misalign_o/misalign_addr_o.
module pc_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter int unsigned STEP       = 4,
  parameter int unsigned BOOT_DELAY = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_addr_i,
  input  logic              jump_valid_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              stall_i,
  input  logic              halt_i,
  input  logic              resume_i,
  input  logic              fetch_ready_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              fetch_valid_o,
  output logic [1:0]        state_o,
`ifdef PC_ALIGN_CHK_EN
  output logic              misalign_o,
  output logic [ADDR_W-1:0] misalign_addr_o,
`endif
  output logic              pend_o
);

  localparam int unsigned       CNT_W    = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BOOT_DELAY - 1);
  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);
`ifdef PC_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
`endif

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              redir_en;
  logic [ADDR_W-1:0] redir_addr;
`ifdef PC_ALIGN_CHK_EN
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] mis_addr_q, mis_addr_d;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    redir_en    = 1'b0;
    redir_addr  = '0;
`ifdef PC_ALIGN_CHK_EN
    mis_d       = 1'b0;
    mis_addr_d  = mis_addr_q;
`endif

    case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (trap_valid_i) begin
          pend_d     = 1'b0;
          redir_en   = 1'b1;
          redir_addr = trap_addr_i;
        end else if (jump_valid_i && !stall_i) begin
          pend_d     = 1'b0;
          redir_en   = 1'b1;
          redir_addr = jump_addr_i;
        end else if (jump_valid_i && stall_i) begin
          pend_d      = 1'b1;
          pend_addr_d = jump_addr_i;
        end else if (pend_q && !stall_i) begin
          pend_d     = 1'b0;
          redir_en   = 1'b1;
          redir_addr = pend_addr_q;
        end else if (fetch_ready_i && !stall_i && !halt_i) begin
          pc_d = pc_q + STEP_INC;
        end
        if (halt_i) state_d = ST_HALT;
      end
      ST_HALT: begin
        // Pending jump survives HALT; only a trap overrides it.
        if (trap_valid_i) begin
          pend_d     = 1'b0;
          redir_en   = 1'b1;
          redir_addr = trap_addr_i;
          state_d    = ST_RUN;
        end else if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Redirect targets funnel through one point so the alignment gate covers all of them.
`ifdef PC_ALIGN_CHK_EN
    if (redir_en) begin
      if ((redir_addr & ALIGN_MASK) != '0) begin
        mis_d      = 1'b1;
        mis_addr_d = redir_addr;
      end else begin
        pc_d = redir_addr;
      end
    end
`else
    if (redir_en) pc_d = redir_addr;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_BOOT;
      pc_q        <= RST_PC;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
`ifdef PC_ALIGN_CHK_EN
      mis_q       <= 1'b0;
      mis_addr_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
`ifdef PC_ALIGN_CHK_EN
      mis_q       <= mis_d;
      mis_addr_q  <= mis_addr_d;
`endif
    end
  end

  assign pc_o          = pc_q;
  assign pend_o        = pend_q;
  assign state_o       = state_q;
  assign fetch_valid_o = (state_q == ST_RUN) && !stall_i;
`ifdef PC_ALIGN_CHK_EN
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: expected outputs are queued per driven cycle and compared after the edge.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;
  localparam logic [1:0]  BOOT = 2'b00, RUN = 2'b01, HALT = 2'b10;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        trap_valid_i, jump_valid_i, stall_i, halt_i, resume_i, fetch_ready_i;
  logic [31:0] trap_addr_i, jump_addr_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o, pend_o;
  logic [1:0]  state_o;
`ifdef PC_ALIGN_CHK_EN
  logic        misalign_o;
  logic [31:0] misalign_addr_o;
`endif

  pc_gen #(
    .ADDR_W    (32),
    .RESET_VEC (RV),
    .STEP      (4),
    .BOOT_DELAY(2)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .trap_valid_i   (trap_valid_i),
    .trap_addr_i    (trap_addr_i),
    .jump_valid_i   (jump_valid_i),
    .jump_addr_i    (jump_addr_i),
    .stall_i        (stall_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .fetch_ready_i  (fetch_ready_i),
    .pc_o           (pc_o),
    .fetch_valid_o  (fetch_valid_o),
    .state_o        (state_o),
`ifdef PC_ALIGN_CHK_EN
    .misalign_o     (misalign_o),
    .misalign_addr_o(misalign_addr_o),
`endif
    .pend_o         (pend_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic        pend;
    logic [1:0]  st;
    logic        fv;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   step_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] epc, input logic epend, input logic [1:0] est, input logic efv);
    exp_t e;
    e.idx = step_n; e.pc = epc; e.pend = epend; e.st = est; e.fv = efv;
    sb.push_back(e);
    step_n++;
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check_eq($sformatf("s%0d pc", e.idx), pc_o, e.pc);
    check_eq($sformatf("s%0d pend", e.idx), {31'd0, pend_o}, {31'd0, e.pend});
    check_eq($sformatf("s%0d state", e.idx), {30'd0, state_o}, {30'd0, e.st});
    check_eq($sformatf("s%0d fvalid", e.idx), {31'd0, fetch_valid_o}, {31'd0, e.fv});
  endtask

  // Drive one cycle of stimulus, queue the post-edge expectation, then compare after the edge.
  task automatic cyc(input logic tr, input logic [31:0] ta, input logic jv, input logic [31:0] ja,
                     input logic st, input logic hl, input logic rs, input logic rd,
                     input logic [31:0] epc, input logic epend, input logic [1:0] est, input logic efv);
    trap_valid_i = tr; trap_addr_i = ta; jump_valid_i = jv; jump_addr_i = ja;
    stall_i = st; halt_i = hl; resume_i = rs; fetch_ready_i = rd;
    push_exp(epc, epend, est, efv);
    @(posedge clk_i);
    #1;
    pop_cmp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1;
    trap_valid_i = 0; trap_addr_i = '0; jump_valid_i = 0; jump_addr_i = '0;
    stall_i = 0; halt_i = 0; resume_i = 0; fetch_ready_i = 0;
    #2;
    push_exp(RV, 1'b0, BOOT, 1'b0);
    pop_cmp();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Boot delay then sequential fetch
    cyc(0,0, 0,0, 0,0,0,1, RV,            0, BOOT, 0);
    cyc(0,0, 0,0, 0,0,0,1, RV,            0, RUN,  1);
    cyc(0,0, 0,0, 0,0,0,1, RV + 32'd4,    0, RUN,  1);
    cyc(0,0, 0,0, 0,0,0,1, RV + 32'd8,    0, RUN,  1);

    // Jumps under stall are buffered; newest wins
    cyc(0,0, 1,32'h100, 1,0,0,1, RV + 32'd8, 1, RUN, 0);
    cyc(0,0, 1,32'h100, 1,0,0,1, RV + 32'd8, 1, RUN, 0);
    cyc(0,0, 1,32'h100, 1,0,0,1, RV + 32'd8, 1, RUN, 0);
    cyc(0,0, 1,32'h200, 1,0,0,1, RV + 32'd8, 1, RUN, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h200,    0, RUN, 1);
    cyc(0,0, 0,0,       0,0,0,1, 32'h204,    0, RUN, 1);

    // Trap beats jump and clears a pending jump, even under stall
    cyc(0,0,       1,32'h300, 1,0,0,1, 32'h204, 1, RUN, 0);
    cyc(1,32'h40,  1,32'h300, 1,0,0,1, 32'h40,  0, RUN, 0);
    cyc(0,0,       0,0,       0,0,0,1, 32'h44,  0, RUN, 1);

    // Halt freezes PC, ignores jumps; resume beats halt
    cyc(0,0, 0,0,       0,1,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 1,32'h500, 0,0,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h44, 0, HALT, 0);
    cyc(0,0, 0,0,       0,1,1,1, 32'h44, 0, RUN,  1);
    cyc(0,0, 0,0,       0,0,0,1, 32'h48, 0, RUN,  1);
    cyc(0,0, 0,0,       0,0,0,1, 32'h4C, 0, RUN,  1);

    // Pending jump survives HALT and applies after resume once stall drops
    cyc(0,0, 1,32'h600, 1,0,0,1, 32'h4C,  1, RUN,  0);
    cyc(0,0, 0,0,       1,1,0,1, 32'h4C,  1, HALT, 0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h4C,  1, HALT, 0);
    cyc(0,0, 0,0,       1,0,1,1, 32'h4C,  1, RUN,  0);
    cyc(0,0, 0,0,       0,0,0,1, 32'h600, 0, RUN,  1);

    // Trap exits HALT
    cyc(0,0,      0,0, 0,1,0,1, 32'h600, 0, HALT, 0);
    cyc(1,32'h80, 0,0, 0,0,0,1, 32'h80,  0, RUN,  1);

    // Wrap at top of address space, ready-low hold, unstalled jump without ready
    cyc(1,32'hFFFF_FFFC, 0,0, 0,0,0,1, 32'hFFFF_FFFC, 0, RUN, 1);
    cyc(0,0,             0,0, 0,0,0,1, 32'h0,         0, RUN, 1);
    cyc(0,0,             0,0, 0,0,0,1, 32'h4,         0, RUN, 1);
    cyc(0,0,             0,0, 0,0,0,0, 32'h4,         0, RUN, 1);
    cyc(0,0, 1,32'h700,  0,0,0,0,      32'h700,       0, RUN, 1);
    cyc(0,0, 1,32'h900,  1,0,0,1,      32'h700,       1, RUN, 0);

    // Asynchronous reset mid-stall with a pending jump
    rst_i = 1'b1;
    #1;
    push_exp(RV, 1'b0, BOOT, 1'b0);
    pop_cmp();
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    cyc(0,0, 0,0, 0,0,0,1, RV,         0, BOOT, 0);
    cyc(0,0, 0,0, 0,0,0,1, RV,         0, RUN,  1);
    cyc(0,0, 0,0, 0,0,0,1, RV + 32'd4, 0, RUN,  1);

`ifdef PC_ALIGN_CHK_EN
    cyc(0,0, 1,32'h102, 0,0,0,0, RV + 32'd4, 0, RUN, 1);
    check_eq("mis_pulse", {31'd0, misalign_o}, 32'd1);
    check_eq("mis_addr", misalign_addr_o, 32'h102);
    cyc(0,0, 0,0,       0,0,0,0, RV + 32'd4, 0, RUN, 1);
    check_eq("mis_clear", {31'd0, misalign_o}, 32'd0);
    cyc(0,0, 1,32'h104, 0,0,0,0, 32'h104,    0, RUN, 1);
    check_eq("mis_aligned", {31'd0, misalign_o}, 32'd0);
`endif

    if (sb.size() != 0) check_eq("scoreboard_left", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
